// File: rtl/multicycle_control_unit.sv
// Multicycle control sequencer: steps each instruction through fetch/decode/execute/
// memory/writeback, drives datapath enables and counts retired instructions.
//
// state   | meaning
// --------+----------------------------------------------
// FETCH   | read instruction at PC, PC <= PC + 1 on ready
// DECODE  | latch opcode/func, precompute branch target
// EXEC_R  | R-type ALU operation on rs, rt
// WB_R    | write R-type result to rd
// ADDR    | rs + imm (address or addi result)
// MEM_RD  | load data read, waits for mem_ready
// WB_MEM  | write loaded data to rt
// MEM_WR  | store data write, waits for mem_ready
// WB_I    | write addi result to rt
// BRANCH  | compare rs/rt, conditional PC update
// JUMP    | PC <= jump target
module multicycle_control_unit #(
  parameter int OPCODE_W  = 4,
  parameter int FUNC_W    = 4,
  parameter int ALUCTRL_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [FUNC_W-1:0]    func,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 branch_ne,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           pc_source,
  output logic [ALUCTRL_W-1:0] alu_control,
  output logic                 illegal,
  output logic [3:0]           state_o,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_WB_MEM = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_I   = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic [FUNC_W-1:0]   fn_q;
  logic                dec_legal;

  // Full-width compares also reject nonzero upper opcode/func bits.
  assign dec_legal = (opcode == '0) ? (func <= FUNC_W'(3)) : (opcode <= OPCODE_W'(6));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      retired <= '0;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_q <= opcode;
          fn_q <= func;
          if (!dec_legal)                     state <= S_FETCH;
          else if (opcode == '0)              state <= S_EXEC_R;
          else if (opcode <= OPCODE_W'(3))    state <= S_ADDR;
          else if (opcode <= OPCODE_W'(5))    state <= S_BRANCH;
          else                                state <= S_JUMP;
        end
        S_EXEC_R: state <= S_WB_R;
        S_ADDR: begin
          if (op_q == OPCODE_W'(1))      state <= S_MEM_RD;
          else if (op_q == OPCODE_W'(2)) state <= S_MEM_WR;
          else                           state <= S_WB_I;
        end
        S_MEM_RD: if (mem_ready) state <= S_WB_MEM;
        S_MEM_WR: begin
          if (mem_ready) begin
            state   <= S_FETCH;
            retired <= retired + CNT_W'(1);
          end
        end
        S_WB_R, S_WB_MEM, S_WB_I, S_BRANCH, S_JUMP: begin
          state   <= S_FETCH;
          retired <= retired + CNT_W'(1);
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  assign state_o = state;

  // Gated by rst_n so no request or enable leaks out while reset is held.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_control   = '0;
    illegal       = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          illegal   = !dec_legal;
        end
        S_EXEC_R: begin
          alu_src_a   = 1'b1;
          alu_control = ALUCTRL_W'(fn_q[1:0]);
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_WB_I:   reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_control   = ALUCTRL_W'(1);
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          branch_ne     = (op_q == OPCODE_W'(5));
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: directed and random instruction streams compared cycle by cycle
// against a per-instruction state/output model; a CNT_W=2 copy checks counter wrap.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic [3:0] func;
  logic       mem_ready;

  logic mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne;
  logic reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [3:0] alu_control, state_o;
  logic [15:0] retired;

  logic mem_read2, mem_write2, iord2, ir_write2, pc_write2, pc_write_cond2, branch_ne2;
  logic reg_write2, reg_dst2, mem_to_reg2, alu_src_a2, illegal2;
  logic [1:0] alu_src_b2, pc_source2;
  logic [3:0] alu_control2, state_o2;
  logic [1:0] retired2;

  int checks = 0;
  int failures = 0;
  int count = 0;

  always #5 clk = ~clk;

  multicycle_control_unit #(.OPCODE_W(4), .FUNC_W(4), .ALUCTRL_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_control(alu_control), .illegal(illegal), .state_o(state_o), .retired(retired)
  );

  multicycle_control_unit #(.OPCODE_W(4), .FUNC_W(4), .ALUCTRL_W(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready),
    .mem_read(mem_read2), .mem_write(mem_write2), .iord(iord2), .ir_write(ir_write2),
    .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .branch_ne(branch_ne2),
    .reg_write(reg_write2), .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2),
    .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .pc_source(pc_source2),
    .alu_control(alu_control2), .illegal(illegal2), .state_o(state_o2), .retired(retired2)
  );

  wire [19:0] act = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, branch_ne,
                     reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
                     alu_control, illegal};
  wire [19:0] act2 = {mem_read2, mem_write2, iord2, ir_write2, pc_write2, pc_write_cond2,
                      branch_ne2, reg_write2, reg_dst2, mem_to_reg2, alu_src_a2, alu_src_b2,
                      pc_source2, alu_control2, illegal2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(int op, int fn);
    return (op == 0) ? (fn <= 3) : (op <= 6);
  endfunction

  // Expected control word for one cycle, taken straight from the state behaviour table.
  function automatic logic [19:0] exp_ctrl(int st, int op, int fn, bit rdy);
    logic mr, mw, io, irw, pcw, pcc, bne, rw, rd, m2r, asa, ill;
    logic [1:0] asb, pcs;
    logic [3:0] alu;
    {mr, mw, io, irw, pcw, pcc, bne, rw, rd, m2r, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; alu = 4'd0;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      1:  begin asb = 2'b11; ill = !is_legal(op, fn); end
      2:  begin asa = 1; alu = 4'(fn); end
      3:  begin rw = 1; rd = 1; end
      4:  begin asa = 1; asb = 2'b10; end
      5:  begin mr = 1; io = 1; end
      6:  begin rw = 1; m2r = 1; end
      7:  begin mw = 1; io = 1; end
      8:  rw = 1;
      9:  begin asa = 1; alu = 4'd1; pcc = 1; pcs = 2'b01; bne = (op == 5); end
      10: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {mr, mw, io, irw, pcw, pcc, bne, rw, rd, m2r, asa, asb, pcs, alu, ill};
  endfunction

  // Entered and left just after a rising edge. wf/wm = not-ready cycles in FETCH/memory.
  task automatic run_instr(int op, int fn, int wf, int wm);
    int seq[$];
    bit rq[$];
    repeat (wf) begin seq.push_back(0); rq.push_back(0); end
    seq.push_back(0); rq.push_back(1);
    seq.push_back(1); rq.push_back(0);
    if (is_legal(op, fn)) begin
      case (op)
        0: begin seq.push_back(2); seq.push_back(3); rq.push_back(0); rq.push_back(0); end
        1, 2: begin
          seq.push_back(4); rq.push_back(0);
          repeat (wm) begin seq.push_back(op == 1 ? 5 : 7); rq.push_back(0); end
          seq.push_back(op == 1 ? 5 : 7); rq.push_back(1);
          if (op == 1) begin seq.push_back(6); rq.push_back(0); end
        end
        3: begin seq.push_back(4); seq.push_back(8); rq.push_back(0); rq.push_back(0); end
        4, 5: begin seq.push_back(9); rq.push_back(0); end
        default: begin seq.push_back(10); rq.push_back(0); end
      endcase
    end
    foreach (seq[i]) begin
      if (seq[i] == 0 || seq[i] == 5 || seq[i] == 7) mem_ready = rq[i];
      else mem_ready = 1'($urandom);
      opcode = (seq[i] == 1) ? 4'(op) : 4'($urandom);
      func   = (seq[i] == 1) ? 4'(fn) : 4'($urandom);
      @(negedge clk);
      chk("state", 32'(state_o), 32'(seq[i]));
      chk("ctrl", 32'(act), 32'(exp_ctrl(seq[i], op, fn, mem_ready)));
      chk("ctrl_w2", 32'(act2), 32'(exp_ctrl(seq[i], op, fn, mem_ready)));
      chk("retired", 32'(retired), 32'(count % 65536));
      chk("retired_w2", 32'(retired2), 32'(count % 4));
      @(posedge clk); #1;
    end
    if (is_legal(op, fn)) count++;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 4'd0; func = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'(act), 32'd0);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int f = 0; f < 4; f++) run_instr(0, f, 0, 0);
    chk("rtype_retired", 32'(retired), 32'd4);
    run_instr(1, 0, 0, 3);
    run_instr(2, 0, 0, 0);
    run_instr(3, 0, 0, 0);
    run_instr(6, 0, 0, 0);
    run_instr(4, 0, 0, 0);
    run_instr(5, 0, 0, 0);
    run_instr(7, 0, 0, 0);
    run_instr(0, 5, 0, 0);
    run_instr(8, 2, 1, 0);
    run_instr(0, 4'hc, 0, 0);
    chk("directed_retired", 32'(retired), 32'd10);

    for (int n = 0; n < 60; n++) begin
      int op;
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 6));
      run_instr(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
    end

    // Reset while a load is waiting in MEM_RD.
    mem_ready = 1'b1; opcode = 4'd1; func = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_state", 32'(state_o), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_ctrl", 32'(act), 32'd0);
    chk("mid_reset_state", 32'(state_o), 32'd0);
    chk("mid_reset_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    count = 0;
    @(negedge clk);
    chk("post_reset_state", 32'(state_o), 32'd0);
    chk("post_reset_retired", 32'(retired), 32'd0);
    @(posedge clk); #1;

    repeat (5) run_instr(6, 0, 0, 0);
    chk("wrap_retired_w2", 32'(retired2), 32'd1);
    chk("jmp5_retired", 32'(retired), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
